// File: rtl/dmem_arbiter.sv
// Two-port (A: load/store unit, B: DMA/debug) arbiter onto a single-port word memory.
// Define DMEM_FIXED_PRIO_EN for fixed A-over-B priority; the default is round-robin.
module dmem_arbiter #(
   parameter int MEM_DEPTH = 1028
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_a_req,
   input  logic        i_a_we,
   input  logic [1:0]  i_a_size,
   input  logic        i_a_unsigned,
   input  logic [12:0] i_a_addr,
   input  logic [31:0] i_a_wdata,
   output logic        o_a_gnt,
   output logic        o_a_rvalid,
   output logic        o_a_err,
   output logic [31:0] o_a_rdata,
   input  logic        i_b_req,
   input  logic        i_b_we,
   input  logic [1:0]  i_b_size,
   input  logic        i_b_unsigned,
   input  logic [12:0] i_b_addr,
   input  logic [31:0] i_b_wdata,
   output logic        o_b_gnt,
   output logic        o_b_rvalid,
   output logic        o_b_err,
   output logic [31:0] o_b_rdata,
   output logic        o_mem_write,
   output logic [10:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata
);

   localparam logic [11:0] DEPTH_W = 12'(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic        any_req, grant_b, grant_en;
   logic        owner_b_p0, we_p0, uns_p0;
   logic [1:0]  size_p0;
   logic [12:0] addr_p0;
   logic [31:0] wdata_p0;
   logic        acc_err;
   logic        err_p1;
   logic [31:0] rdata_p1;

   function automatic logic check_err(input logic [1:0] size, input logic [12:0] addr);
      logic bad;
      bad = 1'b0;
      case (size)
         2'b01:   bad = addr[0];
         2'b10:   bad = (addr[1:0] != 2'b00);
         2'b11:   bad = 1'b1;
         default: bad = 1'b0;
      endcase
      if ({1'b0, addr[12:2]} >= DEPTH_W) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] w;
      w = old;
      case (size)
         2'b00:   w[{off, 3'b000} +: 8] = wdata[7:0];
         2'b01:   w[{off[1], 4'b0000} +: 16] = wdata[15:0];
         default: w = wdata;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Arbitration: gnt is only offered from IDLE and is masked while reset is held.
   assign any_req  = i_a_req | i_b_req;
   assign grant_en = (state_q == IDLE) && i_rstn && any_req;

`ifdef DMEM_FIXED_PRIO_EN
   assign grant_b = i_b_req && !i_a_req;
`else
   logic prefer_b_q;

   assign grant_b = i_b_req && (!i_a_req || prefer_b_q);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)       prefer_b_q <= 1'b0;
      else if (grant_en) prefer_b_q <= !grant_b;
   end
`endif

   assign o_a_gnt = grant_en && !grant_b;
   assign o_b_gnt = grant_en && grant_b;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= IDLE;
         owner_b_p0 <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant_en) owner_b_p0 <= grant_b;
      end
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE:    state_d = any_req ? ACCESS : IDLE;
         ACCESS:  state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Stage 0: winner's request fields captured at grant.
   always_ff @(posedge i_clk) begin
      if (grant_en) begin
         we_p0    <= grant_b ? i_b_we       : i_a_we;
         size_p0  <= grant_b ? i_b_size     : i_a_size;
         uns_p0   <= grant_b ? i_b_unsigned : i_a_unsigned;
         addr_p0  <= grant_b ? i_b_addr     : i_a_addr;
         wdata_p0 <= grant_b ? i_b_wdata    : i_a_wdata;
      end
   end

   assign acc_err = check_err(size_p0, addr_p0);

   // Sub-word stores merge into the combinational read of the same word in one cycle.
   always_comb begin
      o_mem_write = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (state_q == ACCESS) begin
         o_mem_addr = addr_p0[12:2];
         if (we_p0 && !acc_err) begin
            o_mem_write = 1'b1;
            o_mem_wdata = merge_store(i_mem_rdata, wdata_p0, size_p0, addr_p0[1:0]);
         end
      end
   end

   // Stage 1: response captured at the end of ACCESS, presented during RESP.
   always_ff @(posedge i_clk) begin
      if (state_q == ACCESS) begin
         err_p1   <= acc_err;
         rdata_p1 <= (we_p0 || acc_err) ? 32'h0
                                         : load_extend(i_mem_rdata, size_p0, addr_p0[1:0], uns_p0);
      end
   end

   assign o_a_rvalid = (state_q == RESP) && !owner_b_p0;
   assign o_b_rvalid = (state_q == RESP) && owner_b_p0;
   assign o_a_err    = o_a_rvalid && err_p1;
   assign o_b_err    = o_b_rvalid && err_p1;
   assign o_a_rdata  = o_a_rvalid ? rdata_p1 : 32'h0;
   assign o_b_rdata  = o_b_rvalid ? rdata_p1 : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed spec scenarios plus randomized traffic
// checked against a byte-level reference memory model.
module tb_dmem_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic        i_a_req, i_a_we, i_a_unsigned;
   logic [1:0]  i_a_size;
   logic [12:0] i_a_addr;
   logic [31:0] i_a_wdata;
   logic        o_a_gnt, o_a_rvalid, o_a_err;
   logic [31:0] o_a_rdata;
   logic        i_b_req, i_b_we, i_b_unsigned;
   logic [1:0]  i_b_size;
   logic [12:0] i_b_addr;
   logic [31:0] i_b_wdata;
   logic        o_b_gnt, o_b_rvalid, o_b_err;
   logic [31:0] o_b_rdata;
   logic        o_mem_write;
   logic [10:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;

   logic [31:0] tb_mem  [0:2047];
   logic [31:0] ref_mem [0:2047];
   logic        pl_en = 1'b0;
   logic [10:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   int total = 0;
   int bad   = 0;
   bit model_prefer_b = 1'b0;

   always #5 i_clk = ~i_clk;

   dmem_arbiter #(.MEM_DEPTH(1028)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn),
      .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_size(i_a_size), .i_a_unsigned(i_a_unsigned),
      .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
      .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_err(o_a_err), .o_a_rdata(o_a_rdata),
      .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_size(i_b_size), .i_b_unsigned(i_b_unsigned),
      .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
      .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_err(o_b_err), .o_b_rdata(o_b_rdata),
      .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata)
   );

   // Behavioural single-port memory with combinational read.
   assign i_mem_rdata = tb_mem[o_mem_addr];
   always @(posedge i_clk) begin
      if (o_mem_write)  tb_mem[o_mem_addr] <= o_mem_wdata;
      else if (pl_en)   tb_mem[pl_addr]    <= pl_data;
   end

   function automatic bit exp_err(input logic [1:0] sz, input logic [12:0] ad);
      int wi;
      wi = int'(ad[12:2]);
      return (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0) || (wi >= 1028);
   endfunction

   function automatic logic [31:0] exp_load(input logic [12:0] ad, input logic [1:0] sz, input bit un);
      logic [31:0] w, v;
      int sh;
      w = ref_mem[ad[12:2]];
      v = w;
      if (sz == 2'd0) begin
         sh = int'(ad[1:0]) * 8;
         v = (w >> sh) & 32'hFF;
         if (!un && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         sh = int'(ad[1]) * 16;
         v = (w >> sh) & 32'hFFFF;
         if (!un && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_store(input logic [12:0] ad, input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] w, mask;
      int sh;
      w = ref_mem[ad[12:2]];
      if (sz == 2'd0) begin
         sh = int'(ad[1:0]) * 8;
         mask = 32'hFF << sh;
         w = (w & ~mask) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
         sh = int'(ad[1]) * 16;
         mask = 32'hFFFF << sh;
         w = (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end else begin
         w = wd;
      end
      return w;
   endfunction

   task automatic preload(input logic [10:0] a, input logic [31:0] v);
      pl_addr = a; pl_data = v; pl_en = 1'b1;
      @(posedge i_clk); #1;
      pl_en = 1'b0;
      ref_mem[a] = v;
   endtask

   task automatic drive(input bit pb, input bit we, input logic [1:0] sz, input bit un,
                        input logic [12:0] ad, input logic [31:0] wd);
      if (!pb) begin
         i_a_we = we; i_a_size = sz; i_a_unsigned = un; i_a_addr = ad; i_a_wdata = wd; i_a_req = 1'b1;
      end else begin
         i_b_we = we; i_b_size = sz; i_b_unsigned = un; i_b_addr = ad; i_b_wdata = wd; i_b_req = 1'b1;
      end
   endtask

   // One complete transaction on a single port; called at posedge+1 with the DUT idle.
   task automatic run_txn(input bit pb, input bit we, input logic [1:0] sz, input bit un,
                          input logic [12:0] ad, input logic [31:0] wd);
      bit e, got, wr;
      logic [31:0] exp_rd, exp_w;
      logic [10:0] wa;
      int n;
      e = exp_err(sz, ad);
      wa = ad[12:2];
      wr = we && !e;
      exp_rd = (we || e) ? 32'h0 : exp_load(ad, sz, un);
      exp_w  = exp_store(ad, sz, wd);
      drive(pb, we, sz, un, ad, wd);
      got = 1'b0;
      for (n = 0; n < 20; n++) begin
         @(negedge i_clk);
         if ((pb ? o_b_gnt : o_a_gnt) === 1'b1) begin got = 1'b1; break; end
      end
      total++;
      if (!got || n != 0) begin
         bad++; $display("FAIL gnt_wait port=%0d waited=%0d required=0", pb, n);
      end
      if (!got) begin
         i_a_req = 1'b0; i_b_req = 1'b0;
         @(posedge i_clk); #1;
         return;
      end
      total++;
      if ((pb ? o_a_gnt : o_b_gnt) !== 1'b0) begin
         bad++; $display("FAIL other_gnt port=%0d got=1 required=0", pb);
      end
      @(posedge i_clk); #1;
      i_a_req = 1'b0; i_b_req = 1'b0;
      @(negedge i_clk);
      total++;
      if ({o_a_rvalid, o_b_rvalid} !== 2'b00) begin
         bad++; $display("FAIL access_rvalid got=%b required=00", {o_a_rvalid, o_b_rvalid});
      end
      total++;
      if (o_mem_write !== wr) begin
         bad++; $display("FAIL mem_write addr=%h got=%b required=%b", ad, o_mem_write, wr);
      end
      total++;
      if (o_mem_addr !== wa) begin
         bad++; $display("FAIL mem_addr got=%h required=%h", o_mem_addr, wa);
      end
      if (wr) begin
         total++;
         if (o_mem_wdata !== exp_w) begin
            bad++; $display("FAIL mem_wdata addr=%h got=%h required=%h", ad, o_mem_wdata, exp_w);
         end
      end
      @(negedge i_clk);
      total++;
      if ((pb ? o_b_rvalid : o_a_rvalid) !== 1'b1 || (pb ? o_a_rvalid : o_b_rvalid) !== 1'b0) begin
         bad++; $display("FAIL resp_rvalid port=%0d got a=%b b=%b", pb, o_a_rvalid, o_b_rvalid);
      end
      total++;
      if ((pb ? o_b_err : o_a_err) !== e || (pb ? o_a_err : o_b_err) !== 1'b0) begin
         bad++; $display("FAIL resp_err addr=%h size=%0d got=%b required=%b", ad, sz, pb ? o_b_err : o_a_err, e);
      end
      total++;
      if ((pb ? o_b_rdata : o_a_rdata) !== exp_rd || (pb ? o_a_rdata : o_b_rdata) !== 32'h0) begin
         bad++; $display("FAIL resp_rdata addr=%h size=%0d uns=%0d got=%h required=%h",
                         ad, sz, un, pb ? o_b_rdata : o_a_rdata, exp_rd);
      end
      total++;
      if ({o_mem_write, o_mem_addr, o_mem_wdata} !== 44'h0) begin
         bad++; $display("FAIL resp_mem_idle got we=%b addr=%h wdata=%h required 0", o_mem_write, o_mem_addr, o_mem_wdata);
      end
      if (wr) ref_mem[wa] = exp_w;
      model_prefer_b = !pb;
      total++;
      if (tb_mem[wa] !== ref_mem[wa]) begin
         bad++; $display("FAIL mem_content word=%0d got=%h required=%h", wa, tb_mem[wa], ref_mem[wa]);
      end
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      drive(1'b0, 1'b0, 2'd2, 1'b0, 13'h0, 32'h0);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h0, 32'h0);
      #12;
      @(negedge i_clk);
      total++;
      if ({o_a_gnt, o_a_rvalid, o_a_err, o_a_rdata, o_b_gnt, o_b_rvalid, o_b_err, o_b_rdata,
           o_mem_write, o_mem_addr, o_mem_wdata} !== 114'h0) begin
         bad++; $display("FAIL reset_outputs got gnt=%b%b rvalid=%b%b we=%b required all 0",
                         o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_mem_write);
      end
      i_a_req = 1'b0; i_b_req = 1'b0;
      #2 i_rstn = 1'b1;
      model_prefer_b = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_word();
      preload(11'd4, 32'h0);
      run_txn(1'b0, 1'b1, 2'd2, 1'b0, 13'h010, 32'hDEAD_BEEF);
      total++;
      if (tb_mem[4] !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL sw_word got=%h required=deadbeef", tb_mem[4]);
      end
      run_txn(1'b0, 1'b0, 2'd2, 1'b0, 13'h010, 32'h0);
   endtask

   task automatic test_byte();
      preload(11'd4, 32'h1122_3344);
      run_txn(1'b0, 1'b1, 2'd0, 1'b0, 13'h011, 32'h0000_00AA);
      total++;
      if (tb_mem[4] !== 32'h1122_AA44) begin
         bad++; $display("FAIL sb_merge got=%h required=1122aa44", tb_mem[4]);
      end
      run_txn(1'b0, 1'b0, 2'd0, 1'b0, 13'h011, 32'h0);
      run_txn(1'b0, 1'b0, 2'd0, 1'b1, 13'h011, 32'h0);
   endtask

   task automatic test_half();
      preload(11'd4, 32'h8001_5566);
      run_txn(1'b0, 1'b0, 2'd1, 1'b0, 13'h012, 32'h0);
      run_txn(1'b0, 1'b0, 2'd1, 1'b1, 13'h012, 32'h0);
      run_txn(1'b0, 1'b1, 2'd1, 1'b0, 13'h010, 32'h0000_BEEF);
      total++;
      if (tb_mem[4] !== 32'h8001_BEEF) begin
         bad++; $display("FAIL sh_merge got=%h required=8001beef", tb_mem[4]);
      end
   endtask

   task automatic test_errors();
      run_txn(1'b0, 1'b0, 2'd2, 1'b0, 13'h002, 32'h0);
      run_txn(1'b0, 1'b0, 2'd1, 1'b0, 13'h001, 32'h0);
      run_txn(1'b0, 1'b1, 2'd2, 1'b0, 13'h1010, 32'h1234_5678);
      run_txn(1'b1, 1'b1, 2'd3, 1'b0, 13'h004, 32'h1234_5678);
      run_txn(1'b1, 1'b0, 2'd2, 1'b0, 13'h100C, 32'h0);
   endtask

   task automatic test_round_robin();
      bit exp_b;
      drive(1'b0, 1'b0, 2'd2, 1'b0, 13'h000, 32'h0);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h000, 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk);
`ifdef DMEM_FIXED_PRIO_EN
         exp_b = 1'b0;
`else
         exp_b = model_prefer_b;
`endif
         total++;
         if (o_a_gnt !== !exp_b || o_b_gnt !== exp_b) begin
            bad++; $display("FAIL arb_grant k=%0d got a=%b b=%b required b=%b", k, o_a_gnt, o_b_gnt, exp_b);
         end
         model_prefer_b = !exp_b;
         @(posedge i_clk);
         @(posedge i_clk);
         @(negedge i_clk);
         total++;
         if ((exp_b ? o_b_rvalid : o_a_rvalid) !== 1'b1) begin
            bad++; $display("FAIL arb_rvalid k=%0d got a=%b b=%b", k, o_a_rvalid, o_b_rvalid);
         end
         @(posedge i_clk);
      end
      #1;
      i_a_req = 1'b0; i_b_req = 1'b0;
   endtask

   task automatic test_reset_midway();
      preload(11'd8, 32'h1234_5678);
      drive(1'b0, 1'b1, 2'd2, 1'b0, 13'h020, 32'hCAFE_F00D);
      @(negedge i_clk);
      total++;
      if (o_a_gnt !== 1'b1) begin
         bad++; $display("FAIL abort_gnt got=%b required=1", o_a_gnt);
      end
      @(posedge i_clk); #1;
      i_a_req = 1'b0;
      total++;
      if (o_mem_write !== 1'b1) begin
         bad++; $display("FAIL abort_access got=%b required=1", o_mem_write);
      end
      i_rstn = 1'b0;
      #1;
      total++;
      if (o_mem_write !== 1'b0) begin
         bad++; $display("FAIL abort_write got=%b required=0", o_mem_write);
      end
      @(posedge i_clk); #2;
      i_rstn = 1'b1;
      model_prefer_b = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         total++;
         if ({o_a_rvalid, o_b_rvalid, o_mem_write} !== 3'b000) begin
            bad++; $display("FAIL abort_quiet k=%0d got rvalid=%b%b we=%b required 0", k, o_a_rvalid, o_b_rvalid, o_mem_write);
         end
      end
      total++;
      if (tb_mem[8] !== 32'h1234_5678) begin
         bad++; $display("FAIL abort_mem got=%h required=12345678", tb_mem[8]);
      end
      @(posedge i_clk); #1;
      drive(1'b0, 1'b0, 2'd2, 1'b0, 13'h000, 32'h0);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 13'h000, 32'h0);
      @(negedge i_clk);
      total++;
      if (o_a_gnt !== 1'b1 || o_b_gnt !== 1'b0) begin
         bad++; $display("FAIL abort_next_grant got a=%b b=%b required a", o_a_gnt, o_b_gnt);
      end
      model_prefer_b = 1'b1;
      @(posedge i_clk); #1;
      i_a_req = 1'b0; i_b_req = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk); #1;
   endtask

   task automatic test_random();
      logic [10:0] words [13] = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7,
                                  11'd1026, 11'd1027, 11'd1028, 11'd1029, 11'd2047};
      logic [1:0]  sz;
      logic [12:0] ad;
      int r;
      for (int i = 0; i < 13; i++) preload(words[i], $urandom);
      for (int t = 0; t < 80; t++) begin
         r  = int'($urandom_range(0, 15));
         sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
         ad = {words[$urandom_range(0, 12)], 2'($urandom_range(0, 3))};
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                 1'($urandom_range(0, 1)), ad, $urandom);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      i_a_req = 1'b0; i_a_we = 1'b0; i_a_size = 2'd0; i_a_unsigned = 1'b0; i_a_addr = '0; i_a_wdata = '0;
      i_b_req = 1'b0; i_b_we = 1'b0; i_b_size = 2'd0; i_b_unsigned = 1'b0; i_b_addr = '0; i_b_wdata = '0;
      test_reset();
      preload(11'd0, 32'h0BAD_F00D);
      test_word();
      test_byte();
      test_half();
      test_errors();
      test_round_robin();
      test_reset_midway();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
